// File: rtl/memif_pkg.sv
// Shared types and constants for the memory bus interface.
package memif_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RECOVER = 2'd3
   } memif_state_t;

   localparam int BUS_W = 16;
   localparam logic [BUS_W-1:0] ERR_DATA = 16'hFFFF;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state timer for the ACCESS phase: 8-bit saturating counter with
// clear/enable. count_q holds the number of completed ACCESS cycles, so the
// cycle currently in progress is count_q + 1; both thresholds compare that
// 1-based cycle number against the parameters.
module mem_wait_timer
   import memif_pkg::*;
#(
   parameter int WAIT_MIN = 1,
   parameter int TIMEOUT  = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic min_reached,
   output logic expired
);

   localparam logic [8:0] WAIT_MIN_C = 9'(WAIT_MIN);
   localparam logic [8:0] TIMEOUT_C  = 9'(TIMEOUT);

   logic [7:0] count_q;
   logic [7:0] count_d;
   logic [8:0] cycle_s;

   // Next count: clear wins over enable, saturating increment otherwise.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'd0;
      end else if (enable) begin
         count_d = sat_inc8(count_q);
      end else begin
         count_d = count_q;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // Threshold decode on the 1-based number of the current ACCESS cycle.
   always_comb begin
      cycle_s     = {1'b0, count_q} + 9'd1;
      min_reached = (cycle_s >= WAIT_MIN_C);
      expired     = (cycle_s == TIMEOUT_C);
   end

endmodule

// File: rtl/mem_bus_if.sv
// Memory bus interface: runs single-word read/write transactions on the
// external bus for the datapath, with wait states, ready handshake and a
// sticky timeout error. Strobes and DataValid are registered from the
// next-state decode so they line up exactly with ACCESS / RECOVER.
module mem_bus_if
   import memif_pkg::*;
#(
   parameter int WAIT_MIN = 1,
   parameter int TIMEOUT  = 15
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [BUS_W-1:0] SysBus,
   input  logic             AddrWe,
   input  logic             ReadReq,
   input  logic             WriteReq,
   input  logic             ErrClr,
   output logic [BUS_W-1:0] DataIn,
   output logic             DataValid,
   output logic             Stall,
   output logic             BusErr,
   output logic [BUS_W-1:0] MemAddr,
   output logic [BUS_W-1:0] MemWData,
   input  logic [BUS_W-1:0] MemRData,
   output logic             MemRead,
   output logic             MemWrite,
   input  logic             MemReady
);

   memif_state_t     state_q, state_d;
   logic             op_write_q, op_write_d;
   logic [BUS_W-1:0] mem_addr_q, mem_addr_d;
   logic [BUS_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [BUS_W-1:0] data_in_q, data_in_d;
   logic             data_valid_q, data_valid_d;
   logic             bus_err_q, bus_err_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic             timeout_s;
   logic             min_reached_s;
   logic             expired_s;

   mem_wait_timer #(
      .WAIT_MIN (WAIT_MIN),
      .TIMEOUT  (TIMEOUT)
   ) u_timer (
      .clk         (Clock),
      .rst         (Reset),
      .clear       (state_q == SETUP),
      .enable      (state_q == ACCESS),
      .min_reached (min_reached_s),
      .expired     (expired_s)
   );

   // Next-state and datapath register decode; requests only act in IDLE.
   always_comb begin
      state_d     = state_q;
      op_write_d  = op_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      data_in_d   = data_in_q;
      timeout_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (WriteReq) begin
               // Write takes priority; a simultaneous read or AddrWe is dropped.
               state_d     = SETUP;
               op_write_d  = 1'b1;
               mem_wdata_d = SysBus;
            end else if (ReadReq) begin
               state_d    = SETUP;
               op_write_d = 1'b0;
               if (AddrWe) begin
                  mem_addr_d = SysBus;
               end else begin
                  mem_addr_d = mem_addr_q;
               end
            end else if (AddrWe) begin
               mem_addr_d = SysBus;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (MemReady && min_reached_s) begin
               state_d = RECOVER;
               if (op_write_q) begin
                  data_in_d = data_in_q;
               end else begin
                  data_in_d = MemRData;
               end
            end else if (expired_s) begin
               state_d   = RECOVER;
               timeout_s = 1'b1;
               if (op_write_q) begin
                  data_in_d = data_in_q;
               end else begin
                  data_in_d = ERR_DATA;
               end
            end else begin
               state_d = ACCESS;
            end
         end
         RECOVER: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Timeout set beats a same-cycle clear.
      if (timeout_s) begin
         bus_err_d = 1'b1;
      end else if (ErrClr) begin
         bus_err_d = 1'b0;
      end else begin
         bus_err_d = bus_err_q;
      end

      data_valid_d = (state_d == RECOVER) && !op_write_q;
      mem_read_d   = (state_d == ACCESS) && !op_write_d;
      mem_write_d  = (state_d == ACCESS) && op_write_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= IDLE;
         op_write_q   <= 1'b0;
         mem_addr_q   <= 16'h0000;
         mem_wdata_q  <= 16'h0000;
         data_in_q    <= 16'h0000;
         data_valid_q <= 1'b0;
         bus_err_q    <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_write_q   <= op_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         data_in_q    <= data_in_d;
         data_valid_q <= data_valid_d;
         bus_err_q    <= bus_err_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
      end
   end

   // Stall also covers the request cycle so the control unit holds at once.
   assign Stall     = (state_q != IDLE) | ReadReq | WriteReq;
   assign DataIn    = data_in_q;
   assign DataValid = data_valid_q;
   assign BusErr    = bus_err_q;
   assign MemAddr   = mem_addr_q;
   assign MemWData  = mem_wdata_q;
   assign MemRead   = mem_read_q;
   assign MemWrite  = mem_write_q;

endmodule
